conv_feeder: RTL and testbench



---
 rtl/conv_feeder.sv | 190 +++++++++++++++++++
 tb/tb_conv_feeder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_feeder.sv
// conv_feeder: holds an image and a 3x3 kernel loaded by the host.
// It walks every valid 3x3 window in raster order and sends each window to the
// conv datapath as three row beats. It then waits for the conv result and
// returns it to the host, tagged with the window coordinates.
module conv_feeder #(
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 8,
  parameter int FIN_TIMEOUT = 64,
  localparam int AW = $clog2(IMG_W*IMG_H),
  localparam int XW = $clog2(IMG_W),
  localparam int YW = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_we,
  input  logic [AW-1:0] pix_addr,
  input  logic [7:0]    pix_wdata,
  input  logic          wt_we,
  input  logic [3:0]    wt_addr,
  input  logic [7:0]    wt_wdata,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err_timeout,
  output logic [23:0]   data,
  output logic [23:0]   wt,
  output logic          send,
  input  logic [15:0]   output_data,
  input  logic          fin,
  output logic          res_valid,
  output logic [15:0]   res_data,
  output logic [XW-1:0] res_x,
  output logic [YW-1:0] res_y
);

  localparam int NPIX = IMG_W*IMG_H;
  localparam int CW   = $clog2(FIN_TIMEOUT+1);

  typedef enum logic [2:0] {
    IDLE,
    SEND0,
    SEND1,
    SEND2,
    WAIT,
    DONE
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [XW-1:0] win_x;
  logic [YW-1:0] win_y;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    row_sel;
  logic          last_window;
  logic          end_of_row;
  logic          timeout_hit;

  logic [7:0] pix_mem [NPIX];
  logic [7:0] wt_mem  [9];

  assign end_of_row  = (win_x == XW'(IMG_W-3));
  assign last_window = end_of_row && (win_y == YW'(IMG_H-3));
  assign timeout_hit = (wait_cnt == CW'(FIN_TIMEOUT-1));

  // Host writes to image and kernel storage, accepted only while idle so a pass sees a stable image
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (pix_we && (int'(pix_addr) < NPIX))
        pix_mem[pix_addr] <= pix_wdata;
      if (wt_we && (wt_addr <= 4'd8))
        wt_mem[wt_addr] <= wt_wdata;
    end
  end

  // Next-state decode plus the row-beat outputs; data/wt stay zero whenever no beat is sent
  always_comb begin
    logic [AW-1:0] pix_idx;
    logic [3:0]    wt_idx;
    next_state = state;
    busy       = 1'b1;
    done       = 1'b0;
    send       = 1'b0;
    row_sel    = 2'd0;
    data       = '0;
    wt         = '0;
    pix_idx    = '0;
    wt_idx     = '0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start)
          next_state = SEND0;
      end
      SEND0: begin
        send       = 1'b1;
        row_sel    = 2'd0;
        next_state = SEND1;
      end
      SEND1: begin
        send       = 1'b1;
        row_sel    = 2'd1;
        next_state = SEND2;
      end
      SEND2: begin
        send       = 1'b1;
        row_sel    = 2'd2;
        next_state = WAIT;
      end
      WAIT: begin
        if (fin)
          next_state = last_window ? DONE : SEND0;
        else if (timeout_hit)
          next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (send) begin
      for (int c = 0; c < 3; c++) begin
        pix_idx = AW'((int'(win_y) + int'(row_sel))*IMG_W + int'(win_x) + c);
        wt_idx  = 4'(3*int'(row_sel) + c);
        data[8*c +: 8] = pix_mem[pix_idx];
        wt[8*c +: 8]   = wt_mem[wt_idx];
      end
    end
  end

  // State register, window walk, fin wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      win_x       <= '0;
      win_y       <= '0;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= next_state;
      if (state == WAIT)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            win_x       <= '0;
            win_y       <= '0;
            err_timeout <= 1'b0;
          end
        end
        WAIT: begin
          if (fin) begin
            if (!last_window) begin
              if (end_of_row) begin
                win_x <= '0;
                win_y <= win_y + 1'b1;
              end else begin
                win_x <= win_x + 1'b1;
              end
            end
          end else if (timeout_hit) begin
            err_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Result capture: one pulse per accepted fin, tagged with the window that produced it
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_x     <= '0;
      res_y     <= '0;
    end else begin
      res_valid <= 1'b0;
      if ((state == WAIT) && fin) begin
        res_valid <= 1'b1;
        res_data  <= output_data;
        res_x     <= win_x;
        res_y     <= win_y;
      end
    end
  end

endmodule

// File: tb/tb_conv_feeder.sv
// Directed bench for conv_feeder on a 4x4 image: window beats, result tagging,
// fin timeout, reset in mid-pass and inputs that must be ignored while busy.
module tb_conv_feeder;

  localparam int IMG_W       = 4;
  localparam int IMG_H       = 4;
  localparam int FIN_TIMEOUT = 64;
  localparam int AW          = 4;
  localparam int XW          = 2;
  localparam int YW          = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_we;
  logic [AW-1:0] pix_addr;
  logic [7:0]    pix_wdata;
  logic          wt_we;
  logic [3:0]    wt_addr;
  logic [7:0]    wt_wdata;
  logic          start;
  logic          busy;
  logic          done;
  logic          err_timeout;
  logic [23:0]   data;
  logic [23:0]   wt;
  logic          send;
  logic [15:0]   output_data;
  logic          fin;
  logic          res_valid;
  logic [15:0]   res_data;
  logic [XW-1:0] res_x;
  logic [YW-1:0] res_y;

  int checks     = 0;
  int errors     = 0;
  int res_count  = 0;
  int done_count = 0;

  conv_feeder #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .FIN_TIMEOUT(FIN_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pix_we(pix_we),
    .pix_addr(pix_addr),
    .pix_wdata(pix_wdata),
    .wt_we(wt_we),
    .wt_addr(wt_addr),
    .wt_wdata(wt_wdata),
    .start(start),
    .busy(busy),
    .done(done),
    .err_timeout(err_timeout),
    .data(data),
    .wt(wt),
    .send(send),
    .output_data(output_data),
    .fin(fin),
    .res_valid(res_valid),
    .res_data(res_data),
    .res_x(res_x),
    .res_y(res_y)
  );

  // Free-running clock, active edge is posedge
  always #5 clk = ~clk;

  // Count result and done pulses on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (res_valid)
      res_count <= res_count + 1;
    if (done)
      done_count <= done_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Entered on a SEND0 cycle; checks the three beats, answers with fin on the
  // second WAIT cycle and checks the tagged result on the cycle after fin.
  task automatic apply_window(input string tag,
                              input logic [23:0] d0, input logic [23:0] d1, input logic [23:0] d2,
                              input logic [23:0] w0, input logic [23:0] w1, input logic [23:0] w2,
                              input int ex, input int ey, input logic [15:0] result, input bit poke);
    check_output({tag, " beat0 send"}, send, 1);
    check_output({tag, " beat0 data"}, data, d0);
    check_output({tag, " beat0 wt"}, wt, w0);
    tick();
    check_output({tag, " beat1 send"}, send, 1);
    check_output({tag, " beat1 data"}, data, d1);
    check_output({tag, " beat1 wt"}, wt, w1);
    tick();
    check_output({tag, " beat2 send"}, send, 1);
    check_output({tag, " beat2 data"}, data, d2);
    check_output({tag, " beat2 wt"}, wt, w2);
    tick();
    check_output({tag, " wait send"}, send, 0);
    check_output({tag, " wait data"}, data, 0);
    check_output({tag, " wait wt"}, wt, 0);
    check_output({tag, " wait busy"}, busy, 1);
    if (poke) begin
      pix_we    = 1'b1;
      pix_addr  = '0;
      pix_wdata = 8'hFF;
      start     = 1'b1;
    end
    tick();
    pix_we = 1'b0;
    start  = 1'b0;
    check_output({tag, " wait2 send"}, send, 0);
    check_output({tag, " wait2 res_valid"}, res_valid, 0);
    fin         = 1'b1;
    output_data = result;
    tick();
    fin         = 1'b0;
    output_data = '0;
    check_output({tag, " res_valid"}, res_valid, 1);
    check_output({tag, " res_data"}, res_data, result);
    check_output({tag, " res_x"}, res_x, ex);
    check_output({tag, " res_y"}, res_y, ey);
  endtask

  // Linear directed sequence
  initial begin
    rst         = 1'b1;
    pix_we      = 1'b0;
    pix_addr    = '0;
    pix_wdata   = '0;
    wt_we       = 1'b0;
    wt_addr     = '0;
    wt_wdata    = '0;
    start       = 1'b0;
    output_data = '0;
    fin         = 1'b0;
    tick();
    tick();
    check_output("reset busy", busy, 0);
    check_output("reset done", done, 0);
    check_output("reset err_timeout", err_timeout, 0);
    check_output("reset send", send, 0);
    check_output("reset res_valid", res_valid, 0);
    check_output("reset data", data, 0);
    check_output("reset wt", wt, 0);
    check_output("reset res_data", res_data, 0);
    check_output("reset res_x", res_x, 0);
    check_output("reset res_y", res_y, 0);
    rst = 1'b0;
    tick();

    $display("[TB] load pix[i]=i, all weights 1");
    for (int i = 0; i < IMG_W*IMG_H; i++) begin
      pix_we    = 1'b1;
      pix_addr  = AW'(i);
      pix_wdata = 8'(i);
      tick();
    end
    pix_we = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wt_we    = 1'b1;
      wt_addr  = 4'(i);
      wt_wdata = 8'd1;
      tick();
    end
    wt_we = 1'b0;

    $display("[TB] pass 1: four windows in raster order");
    start = 1'b1;
    tick();
    start = 1'b0;
    apply_window("p1 w00", 24'h020100, 24'h060504, 24'h0A0908,
                 24'h010101, 24'h010101, 24'h010101, 0, 0, 16'd45, 1'b0);
    apply_window("p1 w10", 24'h030201, 24'h070605, 24'h0B0A09,
                 24'h010101, 24'h010101, 24'h010101, 1, 0, 16'd46, 1'b0);
    apply_window("p1 w01", 24'h060504, 24'h0A0908, 24'h0E0D0C,
                 24'h010101, 24'h010101, 24'h010101, 0, 1, 16'd47, 1'b0);
    apply_window("p1 w11", 24'h070605, 24'h0B0A09, 24'h0F0E0D,
                 24'h010101, 24'h010101, 24'h010101, 1, 1, 16'd48, 1'b0);
    check_output("p1 done pulse", done, 1);
    check_output("p1 done send", send, 0);
    tick();
    check_output("p1 idle done", done, 0);
    check_output("p1 idle busy", busy, 0);
    check_output("p1 result count", res_count, 4);
    check_output("p1 done count", done_count, 1);

    $display("[TB] pass 2: fin never arrives");
    start = 1'b1;
    tick();
    start = 1'b0;
    check_output("to beat0 data", data, 24'h020100);
    tick();
    tick();
    tick();
    repeat (FIN_TIMEOUT-1) tick();
    check_output("to last wait busy", busy, 1);
    check_output("to last wait err", err_timeout, 0);
    check_output("to last wait done", done, 0);
    tick();
    check_output("to err_timeout", err_timeout, 1);
    check_output("to done pulse", done, 1);
    check_output("to res_valid", res_valid, 0);
    tick();
    check_output("to idle busy", busy, 0);
    check_output("to err sticky", err_timeout, 1);
    check_output("to result count", res_count, 4);
    check_output("to done count", done_count, 2);

    $display("[TB] restart clears timeout, then reset during SEND1");
    start = 1'b1;
    tick();
    start = 1'b0;
    check_output("restart err cleared", err_timeout, 0);
    check_output("restart send", send, 1);
    tick();
    check_output("send1 data", data, 24'h060504);
    rst = 1'b1;
    tick();
    check_output("rst send", send, 0);
    check_output("rst busy", busy, 0);
    check_output("rst data", data, 0);
    check_output("rst done", done, 0);
    check_output("rst res_valid", res_valid, 0);
    rst = 1'b0;
    tick();
    check_output("post rst done", done, 0);
    check_output("post rst busy", busy, 0);
    check_output("post rst done count", done_count, 2);

    $display("[TB] load weights 1..9, pass 3 with ignored inputs during WAIT");
    for (int i = 0; i < 9; i++) begin
      wt_we    = 1'b1;
      wt_addr  = 4'(i);
      wt_wdata = 8'(i+1);
      tick();
    end
    wt_we = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    apply_window("p3 w00", 24'h020100, 24'h060504, 24'h0A0908,
                 24'h030201, 24'h060504, 24'h090807, 0, 0, 16'd100, 1'b1);
    apply_window("p3 w10", 24'h030201, 24'h070605, 24'h0B0A09,
                 24'h030201, 24'h060504, 24'h090807, 1, 0, 16'd101, 1'b0);
    apply_window("p3 w01", 24'h060504, 24'h0A0908, 24'h0E0D0C,
                 24'h030201, 24'h060504, 24'h090807, 0, 1, 16'd102, 1'b0);
    apply_window("p3 w11", 24'h070605, 24'h0B0A09, 24'h0F0E0D,
                 24'h030201, 24'h060504, 24'h090807, 1, 1, 16'd103, 1'b0);
    check_output("p3 done pulse", done, 1);
    tick();
    check_output("p3 idle busy", busy, 0);
    check_output("p3 result count", res_count, 8);
    check_output("p3 done count", done_count, 3);

    $display("[TB] late fin in IDLE, then a new pass sees pix[0] unchanged");
    fin         = 1'b1;
    output_data = 16'hBEEF;
    tick();
    fin         = 1'b0;
    output_data = '0;
    check_output("late fin res_valid", res_valid, 0);
    check_output("late fin res_data", res_data, 16'd103);
    check_output("late fin busy", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_output("p4 beat0 data", data, 24'h020100);
    check_output("p4 beat0 wt", wt, 24'h030201);
    check_output("p4 result count", res_count, 8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
